linked_list_fifo_rr_drain: RTL and testbench

- Drain stage directly downstream of the shared multi-queue linked-list FIFO.
- Selects a non-empty queue round-robin, with a per-queue burst quantum, and drives the FIFO's pop/pop_fifo.
- Absorbs the FIFO's 1-cycle registered read latency and presents entries on a valid/ready stream tagged with the source queue index.

---
 rtl/linked_list_fifo_rr_drain.sv | 87 ++++++++
 tb/tb_linked_list_fifo_rr_drain.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/linked_list_fifo_rr_drain.sv
// linked_list_fifo_rr_drain: round-robin, quantum-limited drain of a multi-queue FIFO onto a valid/ready stream
module linked_list_fifo_rr_drain #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFOS      = 8,
  parameter int QUANTUM    = 4,
  parameter int LOG2_FIFOS = $clog2(FIFOS),
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LOG2_DEPTH*FIFOS-1:0] fifo_count,
  input  logic [WIDTH-1:0]            fifo_q,
  output logic                        fifo_pop,
  output logic [LOG2_FIFOS-1:0]       fifo_pop_fifo,
  input  logic [FIFOS-1:0]            queue_en,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data,
  output logic [LOG2_FIFOS-1:0]       m_fifo
);
  localparam int QW = $clog2(QUANTUM + 1);
  logic [LOG2_FIFOS-1:0] grant_q, grant_d, tag_q, tag_d, m_fifo_q, m_fifo_d, spare_fifo_q, spare_fifo_d;
  logic [LOG2_FIFOS-1:0] sel, idx;
  logic [QW-1:0]         qcnt_q, qcnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [WIDTH-1:0]      m_data_q, m_data_d, spare_data_q, spare_data_d;
  logic [FIFOS-1:0]      elig;
  logic                  keep, acc, load, spare_load;
  for (genvar g = 0; g < FIFOS; g++) begin : g_elig
    assign elig[g] = queue_en[g] & (|fifo_count[(g+1)*LOG2_DEPTH-1 -: LOG2_DEPTH]);
  end
  // Descending scan so the nearest eligible queue after the grant wins; i=FIFOS wraps to the grant itself.
  always_comb begin
    keep = elig[grant_q] && (qcnt_q < QW'(QUANTUM));
    sel = grant_q;
    idx = '0;
    for (int i = FIFOS; i >= 1; i--) begin
      idx = LOG2_FIFOS'((int'(grant_q) + i) % FIFOS);
      if (elig[idx]) sel = idx;
    end
    if (keep) sel = grant_q;
  end
  always_comb begin
    acc = (occ_q != 2'd0) && m_ready;
    fifo_pop = rst && (|elig) && ((3'(occ_q) + 3'(inflight_q) - 3'(acc)) < 3'd2);
    fifo_pop_fifo = sel;
    grant_d = fifo_pop ? sel : grant_q;
    qcnt_d = !fifo_pop ? qcnt_q : keep ? qcnt_q + QW'(1) : QW'(1);
    tag_d = fifo_pop ? sel : tag_q;
    inflight_d = fifo_pop;
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, acc};
    load = acc || (occ_q == 2'd0 && inflight_q);
    m_data_d = !load ? m_data_q : (occ_q == 2'd2) ? spare_data_q : fifo_q;
    m_fifo_d = !load ? m_fifo_q : (occ_q == 2'd2) ? spare_fifo_q : tag_q;
    spare_load = inflight_q && ((occ_q == 2'd2) ? acc : (occ_q == 2'd1 && !acc));
    spare_data_d = spare_load ? fifo_q : spare_data_q;
    spare_fifo_d = spare_load ? tag_q : spare_fifo_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= '0;
      qcnt_q       <= '0;
      tag_q        <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      m_data_q     <= '0;
      m_fifo_q     <= '0;
      spare_data_q <= '0;
      spare_fifo_q <= '0;
    end else begin
      grant_q      <= grant_d;
      qcnt_q       <= qcnt_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      m_data_q     <= m_data_d;
      m_fifo_q     <= m_fifo_d;
      spare_data_q <= spare_data_d;
      spare_fifo_q <= spare_fifo_d;
    end
  end
  assign m_valid = occ_q != 2'd0;
  assign m_data  = m_data_q;
  assign m_fifo  = m_fifo_q;
endmodule

// File: tb/tb_linked_list_fifo_rr_drain.sv
// tb_linked_list_fifo_rr_drain: directed vectors against a behavioural upstream FIFO and hand-written expected streams
module tb_linked_list_fifo_rr_drain;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] fifo_count;
  logic [7:0]  fifo_q = '0;
  logic        fifo_pop;
  logic [2:0]  fifo_pop_fifo;
  logic [7:0]  queue_en = 8'hFF;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic [2:0]  m_fifo;
  logic [7:0]  mem [8][32];
  int          wr [8] = '{default: 0};
  int          rd [8] = '{default: 0};
  int          pop_n = 0;
  logic [2:0]  pop_log [256];
  logic [10:0] exp_e [64];
  int          exp_wr = 0, exp_rd = 0, nvec = 0, nerr = 0, base = 0;
  typedef struct { logic [7:0] nz; logic [7:0] en; logic pop; logic [2:0] f; } vec_t;
  vec_t vt [11];
  always #5 clk = ~clk;
  linked_list_fifo_rr_drain dut (
    .clk(clk), .rst(rst), .fifo_count(fifo_count), .fifo_q(fifo_q), .fifo_pop(fifo_pop),
    .fifo_pop_fifo(fifo_pop_fifo), .queue_en(queue_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_fifo(m_fifo)
  );
  always_comb for (int g = 0; g < 8; g++) fifo_count[g*5 +: 5] = 5'(wr[g] - rd[g]);
  // upstream model: registered read data, count drops on the pop edge
  always @(posedge clk) begin
    if (rst && fifo_pop) begin
      fifo_q <= mem[fifo_pop_fifo][rd[fifo_pop_fifo] % 32];
      rd[fifo_pop_fifo] <= rd[fifo_pop_fifo] + 1;
      pop_log[pop_n % 256] <= fifo_pop_fifo;
      pop_n <= pop_n + 1;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask
  task automatic push(input int g, input logic [7:0] d);
    mem[g][wr[g] % 32] = d;
    wr[g]++;
  endtask
  task automatic expq(input int f, input logic [7:0] d);
    exp_e[exp_wr % 64] = {f[2:0], d};
    exp_wr++;
  endtask
  task automatic tick();
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (exp_rd >= exp_wr) chk("stream unexpected entry", {m_fifo, m_data}, -1);
      else chk($sformatf("stream entry %0d fifo/data", exp_rd), {m_fifo, m_data}, exp_e[exp_rd % 64]);
      exp_rd++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int k = 0;
    while (exp_rd < exp_wr && k < 30) begin
      tick();
      k++;
    end
    chk("stream entries outstanding", exp_wr - exp_rd, 0);
  endtask
  task automatic chk_pops(input string n, input int b, input string s);
    chk({n, " pop count"}, pop_n - b, s.len());
    for (int i = 0; i < s.len(); i++)
      chk($sformatf("%s pop%0d queue", n, i), int'(pop_log[(b + i) % 256]), int'(s[i]) - 48);
  endtask
  task automatic do_reset(input logic [7:0] en);
    rst = 1'b0;
    #1;
    for (int g = 0; g < 8; g++) wr[g] = rd[g];
    exp_rd = exp_wr;
    queue_en = en;
    m_ready = 1'b1;
  endtask
  task automatic release_rst();
    base = pop_n;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask
  initial begin
    // grant=0, qcnt=0 after reset: selection table
    vt[0]  = '{8'h00, 8'hFF, 1'b0, 3'd0};
    vt[1]  = '{8'h01, 8'hFF, 1'b1, 3'd0};
    vt[2]  = '{8'h28, 8'hFF, 1'b1, 3'd3};
    vt[3]  = '{8'h01, 8'hFE, 1'b0, 3'd0};
    vt[4]  = '{8'h81, 8'hFE, 1'b1, 3'd7};
    vt[5]  = '{8'h80, 8'h7F, 1'b0, 3'd0};
    vt[6]  = '{8'h06, 8'hFF, 1'b1, 3'd1};
    vt[7]  = '{8'hFF, 8'h00, 1'b0, 3'd0};
    vt[8]  = '{8'hFF, 8'hFF, 1'b1, 3'd0};
    vt[9]  = '{8'hC0, 8'hFF, 1'b1, 3'd6};
    vt[10] = '{8'hFE, 8'hFD, 1'b1, 3'd2};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      for (int g = 0; g < 8; g++) begin
        wr[g] = rd[g];
        if (vt[i].nz[g]) begin
          push(g, 8'h11);
          push(g, 8'h22);
        end
      end
      queue_en = vt[i].en;
      rst = 1'b1;
      #1;
      chk($sformatf("vec%0d fifo_pop", i), fifo_pop, vt[i].pop);
      if (vt[i].pop) chk($sformatf("vec%0d fifo_pop_fifo", i), fifo_pop_fifo, vt[i].f);
      rst = 1'b0;
    end
    // test 1: two queues, reset values, 2-cycle latency
    do_reset(8'hFF);
    push(0, 8'hA0); push(0, 8'hA1); push(3, 8'hB0); push(3, 8'hB1);
    #1;
    chk("t1 reset m_valid", m_valid, 0);
    chk("t1 reset m_data", m_data, 0);
    chk("t1 reset m_fifo", m_fifo, 0);
    chk("t1 reset fifo_pop", fifo_pop, 0);
    expq(0, 8'hA0); expq(0, 8'hA1); expq(3, 8'hB0); expq(3, 8'hB1);
    release_rst();
    chk("t1 first pop", fifo_pop, 1);
    tick();
    tick();
    chk("t1 latency m_valid", m_valid, 1);
    chk("t1 latency m_data", m_data, 8'hA0);
    drain();
    chk_pops("t1", base, "0033");
    // test 2: quantum expiry and switch back
    do_reset(8'hFF);
    for (int i = 0; i < 6; i++) push(5, 8'h50 + 8'(i));
    push(6, 8'h60);
    expq(5, 8'h50); expq(5, 8'h51); expq(5, 8'h52); expq(5, 8'h53);
    expq(6, 8'h60); expq(5, 8'h54); expq(5, 8'h55);
    release_rst();
    drain();
    chk_pops("t2", base, "5555655");
    // test 3: backpressure holds two entries
    do_reset(8'hFF);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1, 8'h10 + 8'(i));
    release_rst();
    repeat (6) tick();
    chk("t3 stalled pop count", pop_n - base, 2);
    chk("t3 stalled m_valid", m_valid, 1);
    chk("t3 stalled m_data", m_data, 8'h10);
    chk("t3 stalled m_fifo", m_fifo, 1);
    chk("t3 stalled fifo_pop", fifo_pop, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) expq(1, 8'h10 + 8'(i));
    drain();
    chk_pops("t3", base, "11111");
    // test 4: lone queue 7 re-granted to itself, then wrap 7->0
    do_reset(8'hFF);
    for (int i = 0; i < 10; i++) push(7, 8'h70 + 8'(i));
    for (int i = 0; i < 8; i++) expq(7, 8'h70 + 8'(i));
    expq(0, 8'h01); expq(0, 8'h02); expq(7, 8'h78); expq(7, 8'h79);
    release_rst();
    repeat (5) tick();
    chk("t4 pops before fill", pop_n - base, 5);
    push(0, 8'h01); push(0, 8'h02);
    drain();
    chk_pops("t4", base, "777777770077");
    // test 5: masked queue, unmask takes effect same cycle
    do_reset(8'hFE);
    push(0, 8'h5A);
    release_rst();
    repeat (3) tick();
    chk("t5 masked pop count", pop_n - base, 0);
    chk("t5 masked fifo_pop", fifo_pop, 0);
    queue_en = 8'hFF;
    #1;
    chk("t5 unmask fifo_pop", fifo_pop, 1);
    chk("t5 unmask fifo_pop_fifo", fifo_pop_fifo, 0);
    expq(0, 8'h5A);
    drain();
    chk_pops("t5", base, "0");
    // test 6: asynchronous reset mid-burst
    do_reset(8'hFF);
    for (int i = 0; i < 4; i++) push(2, 8'h20 + 8'(i));
    push(4, 8'h40); push(4, 8'h41);
    expq(2, 8'h20);
    release_rst();
    repeat (3) tick();
    chk("t6 pops before reset", pop_n - base, 3);
    chk("t6 m_valid before reset", m_valid, 1);
    rst = 1'b0;
    #1;
    chk("t6 reset m_valid", m_valid, 0);
    chk("t6 reset fifo_pop", fifo_pop, 0);
    chk("t6 reset m_data", m_data, 0);
    chk("t6 reset m_fifo", m_fifo, 0);
    exp_rd = exp_wr;
    expq(2, 8'h23); expq(4, 8'h40); expq(4, 8'h41);
    release_rst();
    chk("t6 release fifo_pop", fifo_pop, 1);
    chk("t6 release fifo_pop_fifo", fifo_pop_fifo, 2);
    drain();
    chk_pops("t6", base, "244");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
